// File: rtl/ddr3_iod_dly_pkg.sv
// ----------------------------------------------------------------------------
// ddr3_iod_dly_pkg
// Shared types and constants for the DDR3 IOD delay-line sequencer.
//   TAP_W_DEF   : default tap counter width
//   dly_state_e : sequencer states
//   max_u       : elaboration-time helper used to size the shared timer
// ----------------------------------------------------------------------------
package ddr3_iod_dly_pkg;

    localparam int unsigned TAP_W_DEF = 8;

    typedef enum logic [2:0] {
        ST_INIT_LOAD = 3'd0,
        ST_SETTLE    = 3'd1,
        ST_IDLE      = 3'd2,
        ST_DIR       = 3'd3,
        ST_MOVE      = 3'd4,
        ST_GAP       = 3'd5,
        ST_FIN       = 3'd6
    } dly_state_e;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ddr3_iod_dly_if.sv
// ----------------------------------------------------------------------------
// ddr3_iod_dly_if
// Request/status bundle between the training logic (master) and the
// delay-line sequencer (slave).
//   REQ_VALID / REQ_READY : request handshake
//   REQ_LOAD              : reload the delay line to its static tap
//   REQ_TAP               : absolute target tap
//   DONE                  : one-cycle completion pulse
//   ERR_RANGE             : last request aborted on IOD saturation (sticky)
//   CUR_TAP               : tracked current tap
// ----------------------------------------------------------------------------
interface ddr3_iod_dly_if
    import ddr3_iod_dly_pkg::*;
#(
    parameter int unsigned TAP_W = TAP_W_DEF
);

    logic             REQ_VALID;
    logic             REQ_READY;
    logic             REQ_LOAD;
    logic [TAP_W-1:0] REQ_TAP;
    logic             DONE;
    logic             ERR_RANGE;
    logic [TAP_W-1:0] CUR_TAP;

    modport master (
        output REQ_VALID,
        output REQ_LOAD,
        output REQ_TAP,
        input  REQ_READY,
        input  DONE,
        input  ERR_RANGE,
        input  CUR_TAP
    );

    modport slave (
        input  REQ_VALID,
        input  REQ_LOAD,
        input  REQ_TAP,
        output REQ_READY,
        output DONE,
        output ERR_RANGE,
        output CUR_TAP
    );

endinterface

// File: rtl/ddr3_iod_dly_timer.sv
// ----------------------------------------------------------------------------
// ddr3_iod_dly_timer
// Loadable down-counter shared by the GAP and SETTLE waits. Loading N gives
// N+1 cycles (counts N..0) before expired_c is seen in the waiting state.
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   load      : load load_val on the next edge (wins over counting)
//   load_val  : value to load
//   expired_c : count has reached zero (combinational from the count flop)
// ----------------------------------------------------------------------------
module ddr3_iod_dly_timer
    import ddr3_iod_dly_pkg::*;
#(
    parameter int unsigned CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             expired_c
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Load has priority; otherwise count down and stick at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_c = (cnt_q == '0);

endmodule

// File: rtl/ddr3_iod_dly_ctrl.sv
// ----------------------------------------------------------------------------
// ddr3_iod_dly_ctrl
// Converts an absolute tap request into the IOD MOVE/DIRECTION/LOAD pulse
// protocol for one delay line, tracking the current tap and reporting IOD
// saturation. Single clock domain (FAB_CLK).
//   FAB_CLK                 : clock, rising edge
//   SYNC_RST                : synchronous active-high reset; replays INIT_LOAD
//   req_if                  : request/status bundle (slave side)
//   DELAY_LINE_MOVE         : one-cycle step pulse to the IOD
//   DELAY_LINE_DIRECTION    : step direction, 1 = increment
//   DELAY_LINE_LOAD         : one-cycle reload pulse to the IOD
//   DELAY_LINE_OUT_OF_RANGE : IOD saturation flag, same clock domain
// ----------------------------------------------------------------------------
module ddr3_iod_dly_ctrl
    import ddr3_iod_dly_pkg::*;
#(
    parameter int unsigned TAP_W         = TAP_W_DEF,
    parameter int unsigned LOAD_TAP      = 1,
    parameter int unsigned MAX_TAP       = 127,
    parameter int unsigned STEP_GAP      = 3,
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic          FAB_CLK,
    input  logic          SYNC_RST,
    ddr3_iod_dly_if.slave req_if,
    output logic          DELAY_LINE_MOVE,
    output logic          DELAY_LINE_DIRECTION,
    output logic          DELAY_LINE_LOAD,
    input  logic          DELAY_LINE_OUT_OF_RANGE
);

    localparam int unsigned TMR_W = $clog2(max_u(STEP_GAP, SETTLE_CYCLES) + 1);

    localparam logic [TAP_W-1:0] LOAD_TAP_V = TAP_W'(LOAD_TAP);
    localparam logic [TAP_W-1:0] MAX_TAP_V  = TAP_W'(MAX_TAP);
    localparam logic [TMR_W-1:0] GAP_LD     = TMR_W'(STEP_GAP - 1);
    localparam logic [TMR_W-1:0] SETTLE_LD  = TMR_W'(SETTLE_CYCLES - 1);

    dly_state_e       state_q,    state_d;
    logic [TAP_W-1:0] cur_tap_q,  cur_tap_d;
    logic [TAP_W-1:0] target_q,   target_d;
    logic             dir_q,      dir_d;
    logic             move_q,     move_d;
    logic             load_q,     load_d;
    logic             done_q,     done_d;
    logic             ready_q,    ready_d;
    logic             err_q,      err_d;
    logic             from_req_q, from_req_d;

    logic             tmr_load_c;
    logic [TMR_W-1:0] tmr_val_c;
    logic             tmr_expired_c;
    logic [TAP_W-1:0] req_tap_clamped_c;
    logic [TAP_W-1:0] tap_step_c;
    logic [TAP_W-1:0] tap_unstep_c;
    logic             accept_c;

    ddr3_iod_dly_timer #(
        .CNT_W (TMR_W)
    ) u_timer (
        .clk       (FAB_CLK),
        .rst       (SYNC_RST),
        .load      (tmr_load_c),
        .load_val  (tmr_val_c),
        .expired_c (tmr_expired_c)
    );

    // Clamp keeps the tracked tap inside [0, MAX_TAP], so it never wraps.
    assign req_tap_clamped_c = (req_if.REQ_TAP > MAX_TAP_V) ? MAX_TAP_V : req_if.REQ_TAP;
    assign accept_c          = req_if.REQ_VALID & ready_q;
    assign tap_step_c        = dir_q ? (cur_tap_q + TAP_W'(1)) : (cur_tap_q - TAP_W'(1));
    assign tap_unstep_c      = dir_q ? (cur_tap_q - TAP_W'(1)) : (cur_tap_q + TAP_W'(1));

    // Next-state and registered-output logic.
    always_comb begin
        state_d    = state_q;
        cur_tap_d  = cur_tap_q;
        target_d   = target_q;
        dir_d      = dir_q;
        err_d      = err_q;
        from_req_d = from_req_q;
        move_d     = 1'b0;
        load_d     = 1'b0;
        done_d     = 1'b0;
        ready_d    = 1'b0;
        tmr_load_c = 1'b0;
        tmr_val_c  = '0;

        unique case (state_q)
            // Out of reset load_q is 0, so the pulse is issued here first;
            // a load request arrives with load_q already set by IDLE.
            ST_INIT_LOAD: begin
                if (!load_q) begin
                    load_d    = 1'b1;
                    cur_tap_d = LOAD_TAP_V;
                end else begin
                    state_d    = ST_SETTLE;
                    tmr_load_c = 1'b1;
                    tmr_val_c  = SETTLE_LD;
                end
            end

            ST_SETTLE: begin
                if (tmr_expired_c) begin
                    if (from_req_q) begin
                        state_d    = ST_FIN;
                        done_d     = 1'b1;
                        from_req_d = 1'b0;
                    end else begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                    end
                end
            end

            ST_IDLE: begin
                ready_d = 1'b1;
                if (accept_c) begin
                    ready_d  = 1'b0;
                    err_d    = 1'b0;
                    target_d = req_tap_clamped_c;
                    if (req_if.REQ_LOAD) begin
                        state_d    = ST_INIT_LOAD;
                        load_d     = 1'b1;
                        cur_tap_d  = LOAD_TAP_V;
                        from_req_d = 1'b1;
                    end else if (req_tap_clamped_c == cur_tap_q) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_DIR;
                        dir_d   = (req_tap_clamped_c > cur_tap_q);
                    end
                end
            end

            // DIRECTION is already stable here, one cycle ahead of the first MOVE.
            ST_DIR: begin
                state_d   = ST_MOVE;
                move_d    = 1'b1;
                cur_tap_d = tap_step_c;
            end

            ST_MOVE: begin
                state_d    = ST_GAP;
                tmr_load_c = 1'b1;
                tmr_val_c  = GAP_LD;
            end

            // Saturation means the IOD ignored the last step: take it back.
            ST_GAP: begin
                if (DELAY_LINE_OUT_OF_RANGE) begin
                    state_d   = ST_FIN;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                    cur_tap_d = tap_unstep_c;
                end else if (tmr_expired_c) begin
                    if (cur_tap_q == target_q) begin
                        state_d = ST_FIN;
                        done_d  = 1'b1;
                    end else begin
                        state_d   = ST_MOVE;
                        move_d    = 1'b1;
                        cur_tap_d = tap_step_c;
                    end
                end
            end

            ST_FIN: begin
                state_d = ST_IDLE;
                ready_d = 1'b1;
            end

            default: begin
                state_d = ST_INIT_LOAD;
            end
        endcase
    end

    // State and output registers; reset replays the init load.
    always_ff @(posedge FAB_CLK) begin
        if (SYNC_RST) begin
            state_q    <= ST_INIT_LOAD;
            cur_tap_q  <= LOAD_TAP_V;
            target_q   <= '0;
            dir_q      <= 1'b0;
            move_q     <= 1'b0;
            load_q     <= 1'b0;
            done_q     <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            from_req_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_tap_q  <= cur_tap_d;
            target_q   <= target_d;
            dir_q      <= dir_d;
            move_q     <= move_d;
            load_q     <= load_d;
            done_q     <= done_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            from_req_q <= from_req_d;
        end
    end

    assign DELAY_LINE_MOVE      = move_q;
    assign DELAY_LINE_DIRECTION = dir_q;
    assign DELAY_LINE_LOAD      = load_q;
    assign req_if.REQ_READY     = ready_q;
    assign req_if.DONE          = done_q;
    assign req_if.ERR_RANGE     = err_q;
    assign req_if.CUR_TAP       = cur_tap_q;

endmodule

// File: tb/tb_ddr3_iod_dly_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ddr3_iod_dly_ctrl
// Directed bench for the IOD delay-line sequencer with LOAD_TAP=1,
// MAX_TAP=127, STEP_GAP=3, SETTLE_CYCLES=4.
// ----------------------------------------------------------------------------
module tb_ddr3_iod_dly_ctrl;

    localparam int unsigned TAP_W = 8;

    logic FAB_CLK = 1'b0;
    logic SYNC_RST;
    logic DELAY_LINE_MOVE;
    logic DELAY_LINE_DIRECTION;
    logic DELAY_LINE_LOAD;
    logic DELAY_LINE_OUT_OF_RANGE;

    ddr3_iod_dly_if #(.TAP_W(TAP_W)) req_if ();

    ddr3_iod_dly_ctrl #(
        .TAP_W         (TAP_W),
        .LOAD_TAP      (1),
        .MAX_TAP       (127),
        .STEP_GAP      (3),
        .SETTLE_CYCLES (4)
    ) dut (
        .FAB_CLK                 (FAB_CLK),
        .SYNC_RST                (SYNC_RST),
        .req_if                  (req_if),
        .DELAY_LINE_MOVE         (DELAY_LINE_MOVE),
        .DELAY_LINE_DIRECTION    (DELAY_LINE_DIRECTION),
        .DELAY_LINE_LOAD         (DELAY_LINE_LOAD),
        .DELAY_LINE_OUT_OF_RANGE (DELAY_LINE_OUT_OF_RANGE)
    );

    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int move_cnt = 0;
    int load_cnt = 0;
    int done_cnt = 0;
    int move_cyc[$];
    int t_acc, d_cyc, r0, m0, l0, d0, q0;

    always #5 FAB_CLK = ~FAB_CLK;

    // Cycle k is the interval following the k-th rising edge.
    always @(posedge FAB_CLK) cyc <= cyc + 1;

    // Pulse monitors, sampled mid-cycle.
    always @(negedge FAB_CLK) begin
        if (DELAY_LINE_MOVE === 1'b1) begin
            move_cnt++;
            move_cyc.push_back(cyc);
        end
        if (DELAY_LINE_LOAD === 1'b1) load_cnt++;
        if (req_if.DONE === 1'b1) done_cnt++;
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: observed cycle %0d expected completion", cyc);
        $fatal(1, "bench timeout");
    end

    task automatic tick();
        @(posedge FAB_CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int mv_at(input int idx);
        return (idx < move_cyc.size()) ? move_cyc[idx] : -1;
    endfunction

    task automatic wait_ready(input int budget);
        int i = 0;
        while (req_if.REQ_READY !== 1'b1 && i < budget) begin
            tick();
            i++;
        end
    endtask

    task automatic wait_done(input int budget, output int dc);
        int i = 0;
        dc = -1;
        while (dc < 0 && i < budget) begin
            tick();
            i++;
            if (req_if.DONE === 1'b1) dc = cyc;
        end
    endtask

    // Present a request once READY is seen; returns one cycle after acceptance.
    task automatic issue(input logic ld, input logic [TAP_W-1:0] tap);
        wait_ready(1000);
        req_if.REQ_LOAD  = ld;
        req_if.REQ_TAP   = tap;
        req_if.REQ_VALID = 1'b1;
        t_acc = cyc;
        m0 = move_cnt;
        l0 = load_cnt;
        d0 = done_cnt;
        q0 = move_cyc.size();
        tick();
        req_if.REQ_VALID = 1'b0;
        req_if.REQ_LOAD  = 1'b0;
    endtask

    initial begin
        SYNC_RST                = 1'b1;
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        req_if.REQ_VALID        = 1'b0;
        req_if.REQ_LOAD         = 1'b0;
        req_if.REQ_TAP          = '0;
        repeat (3) tick();

        // Reset values
        chk("rst_move",  32'(DELAY_LINE_MOVE), 32'd0);
        chk("rst_load",  32'(DELAY_LINE_LOAD), 32'd0);
        chk("rst_dir",   32'(DELAY_LINE_DIRECTION), 32'd0);
        chk("rst_ready", 32'(req_if.REQ_READY), 32'd0);
        chk("rst_done",  32'(req_if.DONE), 32'd0);
        chk("rst_err",   32'(req_if.ERR_RANGE), 32'd0);
        chk("rst_cur",   32'(req_if.CUR_TAP), 32'd1);

        // Reset release: LOAD in cycle 0, READY in cycle 5, no DONE
        l0 = load_cnt;
        d0 = done_cnt;
        SYNC_RST = 1'b0;
        r0 = cyc + 1;
        tick();
        chk("init_load_c0", 32'(DELAY_LINE_LOAD), 32'd1);
        wait_ready(50);
        chk("init_ready_cyc", 32'(cyc), 32'(r0 + 5));
        chk("init_load_cnt", 32'(load_cnt - l0), 32'd1);
        chk("init_no_done", 32'(done_cnt - d0), 32'd0);
        chk("init_cur", 32'(req_if.CUR_TAP), 32'd1);

        // 1 -> 5: four increments, DONE at T+18
        issue(1'b0, 8'd5);
        chk("up_dir", 32'(DELAY_LINE_DIRECTION), 32'd1);
        chk("up_dir_state_no_move", 32'(DELAY_LINE_MOVE), 32'd0);
        wait_done(100, d_cyc);
        chk("up_done_cyc", 32'(d_cyc), 32'(t_acc + 18));
        chk("up_moves", 32'(move_cnt - m0), 32'd4);
        chk("up_mv0_cyc", 32'(mv_at(q0)), 32'(t_acc + 2));
        chk("up_mv1_cyc", 32'(mv_at(q0 + 1)), 32'(t_acc + 6));
        chk("up_mv3_cyc", 32'(mv_at(q0 + 3)), 32'(t_acc + 14));
        chk("up_cur", 32'(req_if.CUR_TAP), 32'd5);
        chk("up_err", 32'(req_if.ERR_RANGE), 32'd0);
        tick();
        chk("up_ready_after", 32'(req_if.REQ_READY), 32'd1);

        // 5 -> 0: five decrements
        issue(1'b0, 8'd0);
        chk("dn_dir", 32'(DELAY_LINE_DIRECTION), 32'd0);
        wait_done(100, d_cyc);
        chk("dn_done_cyc", 32'(d_cyc), 32'(t_acc + 22));
        chk("dn_moves", 32'(move_cnt - m0), 32'd5);
        chk("dn_cur", 32'(req_if.CUR_TAP), 32'd0);

        // 0 -> 200 clamps to 127
        issue(1'b0, 8'd200);
        chk("clamp_dir", 32'(DELAY_LINE_DIRECTION), 32'd1);
        wait_done(1000, d_cyc);
        chk("clamp_done_cyc", 32'(d_cyc), 32'(t_acc + 510));
        chk("clamp_moves", 32'(move_cnt - m0), 32'd127);
        chk("clamp_cur", 32'(req_if.CUR_TAP), 32'd127);

        // Load request: LOAD at T+1, DONE at T+6, tap back to 1
        issue(1'b1, 8'd55);
        chk("ld_pulse", 32'(DELAY_LINE_LOAD), 32'd1);
        wait_done(50, d_cyc);
        chk("ld_done_cyc", 32'(d_cyc), 32'(t_acc + 6));
        chk("ld_load_cnt", 32'(load_cnt - l0), 32'd1);
        chk("ld_no_move", 32'(move_cnt - m0), 32'd0);
        chk("ld_cur", 32'(req_if.CUR_TAP), 32'd1);

        // 1 -> 3
        issue(1'b0, 8'd3);
        wait_done(100, d_cyc);
        chk("to3_done_cyc", 32'(d_cyc), 32'(t_acc + 10));
        chk("to3_cur", 32'(req_if.CUR_TAP), 32'd3);

        // 3 -> 10 with saturation in the gap after the 2nd pulse
        issue(1'b0, 8'd10);
        while (cyc < t_acc + 8) tick();
        DELAY_LINE_OUT_OF_RANGE = 1'b1;
        tick();
        DELAY_LINE_OUT_OF_RANGE = 1'b0;
        chk("oor_done", 32'(req_if.DONE), 32'd1);
        chk("oor_cur", 32'(req_if.CUR_TAP), 32'd4);
        chk("oor_err", 32'(req_if.ERR_RANGE), 32'd1);
        repeat (6) tick();
        chk("oor_moves", 32'(move_cnt - m0), 32'd2);
        chk("oor_done_once", 32'(done_cnt - d0), 32'd1);
        chk("oor_err_sticky", 32'(req_if.ERR_RANGE), 32'd1);
        chk("oor_ready", 32'(req_if.REQ_READY), 32'd1);

        // Equal target: DONE at T+1, ERR cleared by acceptance
        issue(1'b0, 8'd4);
        chk("eq_done", 32'(req_if.DONE), 32'd1);
        chk("eq_err_clr", 32'(req_if.ERR_RANGE), 32'd0);
        chk("eq_not_ready", 32'(req_if.REQ_READY), 32'd0);
        tick();
        chk("eq_ready", 32'(req_if.REQ_READY), 32'd1);
        chk("eq_no_move", 32'(move_cnt - m0), 32'd0);
        chk("eq_no_load", 32'(load_cnt - l0), 32'd0);
        chk("eq_cur", 32'(req_if.CUR_TAP), 32'd4);

        // Reset between moves: the 2nd MOVE (due T+6) must not appear
        issue(1'b0, 8'd20);
        while (cyc < t_acc + 5) tick();
        SYNC_RST = 1'b1;
        tick();
        chk("mr_move", 32'(DELAY_LINE_MOVE), 32'd0);
        chk("mr_load", 32'(DELAY_LINE_LOAD), 32'd0);
        chk("mr_ready", 32'(req_if.REQ_READY), 32'd0);
        chk("mr_cur", 32'(req_if.CUR_TAP), 32'd1);
        tick();
        SYNC_RST = 1'b0;
        r0 = cyc + 1;
        tick();
        chk("mr_reload", 32'(DELAY_LINE_LOAD), 32'd1);
        wait_ready(50);
        chk("mr_ready_cyc", 32'(cyc), 32'(r0 + 5));
        chk("mr_moves", 32'(move_cnt - m0), 32'd1);
        chk("mr_no_done", 32'(done_cnt - d0), 32'd0);
        chk("mr_cur_final", 32'(req_if.CUR_TAP), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ddr3_iod_dly_ctrl.md
# ddr3_iod_dly_ctrl

Sequencer for one DDR3 PHY lane IOD delay line; it converts a requested absolute tap value into the MOVE/DIRECTION/LOAD pulse protocol the IOD expects. It tracks the current tap, spaces moves by a programmable gap, and reports saturation via DELAY_LINE_OUT_OF_RANGE. It sits between the training/calibration logic and the lane's IOD delay-line pins, one instance per IOD, all in the FAB_CLK domain.

## Interface
- TAP_W, 8: tap counter width
- LOAD_TAP, 1: tap value after DELAY_LINE_LOAD; matches IOD static delay value
- MAX_TAP, 127: highest legal tap; requests above it are clamped
- STEP_GAP, 3: idle cycles after each MOVE pulse (≥1)
- SETTLE_CYCLES, 4: idle cycles after each LOAD pulse (≥1)

- FAB_CLK  in  1  sole clock, rising edge
- SYNC_RST  in  1  synchronous, active-high reset
- REQ_VALID  in  1  request present
- REQ_READY  out  1  block can accept a request
- REQ_LOAD  in  1  1 = reload to LOAD_TAP; REQ_TAP ignored
- REQ_TAP  in  TAP_W  absolute target tap
- DONE  out  1  one-cycle completion pulse
- ERR_RANGE  out  1  sticky: last request aborted on out-of-range
- CUR_TAP  out  TAP_W  tracked current tap
- DELAY_LINE_MOVE  out  1  to IOD, one-cycle step pulse
- DELAY_LINE_DIRECTION  out  1  to IOD, 1 = increment
- DELAY_LINE_LOAD  out  1  to IOD, one-cycle reload pulse
- DELAY_LINE_OUT_OF_RANGE  in  1  from IOD, saturation flag

## Operation
- States: INIT_LOAD, SETTLE, IDLE, DIR, MOVE, GAP, FIN.
- Reset values: MOVE=0, LOAD=0, DIRECTION=0, REQ_READY=0, DONE=0, ERR_RANGE=0, CUR_TAP=LOAD_TAP, state=INIT_LOAD.
- INIT_LOAD: DELAY_LINE_LOAD=1 for one cycle, then SETTLE. After SETTLE, go to IDLE; no DONE for the init load.
- IDLE: REQ_READY=1 (only here). Acceptance = REQ_VALID & REQ_READY. Acceptance clears ERR_RANGE and latches target = min(REQ_TAP, MAX_TAP).
- REQ_LOAD accepted: go to INIT_LOAD path (LOAD pulse, CUR_TAP:=LOAD_TAP, SETTLE), then FIN.
- Target == CUR_TAP: go directly to FIN.
- Otherwise go to DIR. DIRECTION := (target > CUR_TAP). DIRECTION is held constant until FIN.
- DIR -> MOVE. MOVE: DELAY_LINE_MOVE=1 for one cycle; CUR_TAP ±1 on that edge. Then GAP.
- GAP: STEP_GAP cycles with MOVE=0.
  - If DELAY_LINE_OUT_OF_RANGE=1 in any GAP cycle: undo the last ±1 on CUR_TAP, set ERR_RANGE, go to FIN next cycle.
  - Else at gap end: MOVE again if CUR_TAP ≠ target, otherwise FIN.
- FIN: DONE=1 for one cycle, REQ_READY=0, then IDLE.
- SYNC_RST mid-sequence: MOVE/LOAD drop at that edge. The block restarts at INIT_LOAD, so the hardware tap and CUR_TAP are resynchronised.
- CUR_TAP never wraps, since target is clamped to [0, MAX_TAP].

## Timing
- Accept in cycle T, step sequence with N steps, G = STEP_GAP:
  - DIR at T+1.
  - MOVE pulses at T+2+k(1+G), k = 0..N−1.
  - DONE at T+2+N(1+G); REQ_READY at T+3+N(1+G).
- Equal target: DONE at T+1, READY at T+2.
- Load request: LOAD pulse at T+1, settle T+2..T+1+SETTLE_CYCLES, DONE at T+2+SETTLE_CYCLES.
- Reset release (first edge with SYNC_RST=0 = cycle 0): LOAD pulse in cycle 0, READY first high in cycle 1+SETTLE_CYCLES.
- Outputs are registered. DELAY_LINE_OUT_OF_RANGE is used directly, with no synchroniser, because it is in the same domain.

## Structure
- Package ddr3_iod_dly_pkg: state enum, TAP_W default constant.
- One sub-module, ddr3_iod_dly_timer: loadable down-counter shared by GAP and SETTLE, with a "expired" output.

## Test plan
Parameters for all scenarios: LOAD_TAP=1, MAX_TAP=127, G=3, SETTLE=4.
- Reset release -> one LOAD pulse, CUR_TAP=1, READY high 5 cycles later, no DONE.
- Request tap 5 from 1 -> DIRECTION=1, 4 MOVE pulses spaced 4 cycles, DONE at T+18, CUR_TAP=5.
- Request tap 0 from 5 -> DIRECTION=0, 5 pulses, CUR_TAP=0; then request 200 -> clamps to 127, 127 pulses.
- From tap 3, request 10 with OUT_OF_RANGE raised in the GAP after the 2nd pulse -> exactly 2 pulses, CUR_TAP=4, ERR_RANGE=1, DONE once; next acceptance clears ERR_RANGE.
- Request the current tap -> DONE at T+1, no MOVE or LOAD; REQ_LOAD request -> LOAD at T+1, DONE at T+6, CUR_TAP=1.
- SYNC_RST asserted between MOVE pulses -> MOVE stays 0, then INIT_LOAD replays, CUR_TAP=1, no DONE for the aborted request.
